muladd_pipe: RTL and testbench
==============================

Name: muladd_pipe

Overview:
- Parametrised, pipelined signed fixed-point dot-product engine; successor to the fixed 4-lane Q8.8 multiply-add.
- Each beat multiplies LANES pairs and sums them; beats accumulate until a beat flagged last, then one saturated DW-bit result is emitted.
- Uses valid/ready on both sides and sits between operand buffers and the result writeback path.

Parameters:
LANES, 4, number of multiplier lanes per beat (>=1)
DW, 16, operand and result width, signed two's complement
FRAC, 8, fractional bits of operands and result (Q(DW-FRAC).FRAC, 0<=FRAC<DW)
ACC_GUARD, 8, extra accumulator bits; packets up to 2^ACC_GUARD beats cannot overflow the accumulator

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
a_flat  input  LANES*DW  lane i operand A at [i*DW +: DW]
b_flat  input  LANES*DW  lane i operand B at [i*DW +: DW]
in_valid  input  1  beat present
in_last  input  1  beat closes current packet
in_ready  output  1  beat accepted when in_valid && in_ready
sum  output  DW  saturated packet result
sat  output  1  result was clamped (qualified by out_valid)
out_valid  output  1  result present
out_ready  input  1  result consumed when out_valid && out_ready

Behaviour:
- Clock is clk; reset rst is synchronous, active-high. On reset: in_ready=0 during reset cycle, out_valid=0, sum=0, sat=0, all stage valids=0, accumulator=0.
- Global enable adv = !out_valid || out_ready. in_ready = adv && !rst. All stages hold when adv=0; no beat is dropped or duplicated.
- Stage M: on accepted beat, register LANES full-precision 2*DW-bit signed products, valid, and last.
- Stage S: register signed lane sum, width 2*DW+clog2(LANES).
- Stage A: ACC_W = 2*DW+clog2(LANES)+ACC_GUARD. When a valid S beat advances, total = acc + lane_sum, sign-extended.
  - If not last: acc <= total.
  - If last: acc <= 0, and the output register loads sat_trunc(total).
- Scaling: arithmetic right shift of total by FRAC, truncating toward -inf. Result is clamped to [-2^(DW-1), 2^(DW-1)-1]; sat=1 iff clamped.
- Latency: last beat accepted at edge t gives out_valid=1 after edge t+3 with zero backpressure. Throughput is one beat per cycle.
- out_valid stays high and sum/sat stay stable until out_ready. When an output is consumed and a new result arrives in the same cycle, the new result loads with no bubble.
- Packets longer than 2^ACC_GUARD beats wrap modulo 2^ACC_W. This is defined, not flagged.
- Stage bubbles (no valid) leave acc unchanged. A single-beat packet has in_last=1 on its first beat.
- Reset mid-packet discards the partial accumulation and all in-flight beats. No output is produced for that packet.
- Changing in_last/a/b while in_valid=1 && in_ready=0 has no effect.

Optional Feature:
- Macro MULADD_PIPE_ROUND_EN.
- When defined: add 2^(FRAC-1) to total before the shift (round half up), then saturate. With FRAC=0, no bias is added.
- When undefined: plain truncation toward -inf as above.
- Latency and handshake are identical in both builds.

Test Plan:
- Defaults, one beat, all lanes a=0x0100 b=0x0200, last=1, out_ready=1 -> sum=0x0800, sat=0, out_valid exactly 3 cycles after accept.
- Three back-to-back beats of the above, last on third -> single result sum=0x1800, one out_valid pulse, in_ready never drops.
- All lanes a=b=0x7FFF, last=1 -> sum=0x7FFF, sat=1. All lanes a=0x8000 b=0x7FFF -> sum=0x8000, sat=1. All lanes a=0xFF00 b=0x0100 -> sum=0xFC00, sat=0.
- Hold out_ready=0 for 5 cycles while streaming single-beat packets -> in_ready=0 once output is held, sum stable; release -> results in order, none lost or duplicated.
- Lane0 a=0x0001 b=0x0080, others 0, last=1 -> sum=0x0000 without macro; sum=0x0001 with MULADD_PIPE_ROUND_EN.
- Two beats of a non-last packet, rst pulsed one cycle, then one-beat packet of 0x0100*0x0100 on lane0 -> only output is sum=0x0100.

Source files
------------

// File: rtl/muladd_pipe.sv
// muladd_pipe: pipelined signed fixed-point dot-product engine.
//
// Each accepted beat multiplies LANES signed DW-bit operand pairs and sums
// the products. Beat sums accumulate until a beat flagged in_last closes
// the packet. The total is then scaled by FRAC bits, clamped to DW bits and
// presented on sum/sat with out_valid.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   a_flat     lane i operand A at [i*DW +: DW]
//   b_flat     lane i operand B at [i*DW +: DW]
//   in_valid   beat present
//   in_last    beat closes the current packet
//   in_ready   beat accepted when in_valid && in_ready
//   sum        saturated packet result
//   sat        result was clamped (qualified by out_valid)
//   out_valid  result present
//   out_ready  result consumed when out_valid && out_ready
//
// Optional build macro: MULADD_PIPE_ROUND_EN
//   defined   -> round half up (add 2^(FRAC-1) before the shift)
//   undefined -> truncate toward -inf
//
// Pipeline: M (products) -> S (lane sum) -> T (accumulator total) -> output.
// A last beat accepted at edge t is visible on out_valid after edge t+3.
module muladd_pipe #(
  parameter int LANES     = 4,
  parameter int DW        = 16,
  parameter int FRAC      = 8,
  parameter int ACC_GUARD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*DW-1:0]   a_flat,
  input  logic [LANES*DW-1:0]   b_flat,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DW-1:0]         sum,
  output logic                  sat,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW    = 2 * DW;
  localparam int SW    = PW + $clog2(LANES);
  localparam int ACC_W = SW + ACC_GUARD;
  // One spare bit so the rounding bias can never wrap the total.
  localparam int EW    = ACC_W + 1;

  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

`ifdef MULADD_PIPE_ROUND_EN
  localparam int RND_IDX = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [EW-1:0] RND_BIAS =
    (FRAC > 0) ? ({{(EW-1){1'b0}}, 1'b1} << RND_IDX) : '0;
`endif

  // Scale the accumulated total down by FRAC bits and clamp to DW bits.
  // Returns {sat, sum}.
  function automatic logic [DW:0] sat_scale(input logic signed [ACC_W-1:0] t);
    logic signed [EW-1:0] x;
    logic signed [EW-1:0] sh;
    x = EW'(t);
`ifdef MULADD_PIPE_ROUND_EN
    x = x + RND_BIAS;
`endif
    sh = x >>> FRAC;
    if (sh > SAT_MAX) begin
      sat_scale = {1'b1, 1'b0, {(DW-1){1'b1}}};
    end else if (sh < SAT_MIN) begin
      sat_scale = {1'b1, 1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_scale = {1'b0, sh[DW-1:0]};
    end
  endfunction

  // Stage M state
  logic signed [PW-1:0]    m_prod_q [LANES];
  logic                    m_valid_q;
  logic                    m_last_q;
  // Stage S state
  logic signed [SW-1:0]    s_sum_q;
  logic                    s_valid_q;
  logic                    s_last_q;
  // Stage T state: accumulator plus the registered running total
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] t_total_q;
  logic                    t_valid_q;
  logic                    t_last_q;
  // Output register
  logic [DW-1:0]           sum_q;
  logic                    sat_q;
  logic                    out_valid_q;

  logic                    adv_s;
  logic signed [PW-1:0]    m_prod_d [LANES];
  logic signed [SW-1:0]    s_sum_d;
  logic signed [ACC_W-1:0] total_d;

  // Whole pipeline moves as one unit; it only stalls behind a held result.
  assign adv_s     = !out_valid_q || out_ready;
  assign in_ready  = adv_s && !rst;
  assign sum       = sum_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

  // Full-precision lane products from the incoming beat.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      m_prod_d[i] = PW'($signed(a_flat[i*DW +: DW])) * PW'($signed(b_flat[i*DW +: DW]));
    end
  end

  // Sign-extended sum of the registered lane products.
  always_comb begin
    s_sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s_sum_d = s_sum_d + SW'(m_prod_q[i]);
    end
  end

  // Running packet total; wraps modulo 2^ACC_W for over-long packets.
  assign total_d = acc_q + ACC_W'(s_sum_q);

  // Pipeline registers, accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        m_prod_q[i] <= '0;
      end
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      s_sum_q     <= '0;
      s_valid_q   <= 1'b0;
      s_last_q    <= 1'b0;
      acc_q       <= '0;
      t_total_q   <= '0;
      t_valid_q   <= 1'b0;
      t_last_q    <= 1'b0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv_s) begin
      m_valid_q <= in_valid;
      m_last_q  <= in_last;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          m_prod_q[i] <= m_prod_d[i];
        end
      end

      s_valid_q <= m_valid_q;
      s_last_q  <= m_last_q;
      s_sum_q   <= s_sum_d;

      // Bubbles leave the accumulator untouched; a last beat restarts it.
      t_valid_q <= s_valid_q;
      t_last_q  <= s_last_q;
      if (s_valid_q) begin
        t_total_q <= total_d;
        acc_q     <= s_last_q ? '0 : total_d;
      end

      // Scaling sits after the accumulator register to keep it off the
      // acc feedback path; it loads only when a packet completes.
      out_valid_q <= t_valid_q && t_last_q;
      if (t_valid_q && t_last_q) begin
        {sat_q, sum_q} <= sat_scale(t_total_q);
      end
    end
  end

endmodule

// File: tb/tb_muladd_pipe.sv
module tb_muladd_pipe;

  localparam int LANES = 4;
  localparam int DW    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [LANES*DW-1:0] a_flat;
  logic [LANES*DW-1:0] b_flat;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [DW-1:0]       sum;
  logic                sat;
  logic                out_valid;
  logic                out_ready;

  always #5 clk = ~clk;

  muladd_pipe #(.LANES(4), .DW(16), .FRAC(8), .ACC_GUARD(8)) dut (
    .clk(clk), .rst(rst), .a_flat(a_flat), .b_flat(b_flat),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sum(sum), .sat(sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] s; logic st; } res_t;
  res_t   exp_q[$];
  res_t   exp_e;
  longint model_acc = 0;
  int     n_out = 0;
  int     held_cycles = 0;

  function automatic longint beat_value(input logic [63:0] a, input logic [63:0] b);
    longint v;
    v = 0;
    for (int i = 0; i < 4; i++)
      v += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
    return v;
  endfunction

  function automatic res_t ref_result(input longint total);
    longint t;
    longint q;
    res_t   r;
    t = (total <<< 22) >>> 22;   // accumulator is 42 bits wide
`ifdef MULADD_PIPE_ROUND_EN
    t = t + 128;
`endif
    q = t >>> 8;
    if (q > 32767) begin
      r.s = 16'h7FFF; r.st = 1'b1;
    end else if (q < -32768) begin
      r.s = 16'h8000; r.st = 1'b1;
    end else begin
      r.s = q[15:0]; r.st = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  logic        hold_prev = 1'b0;
  logic [15:0] sum_prev;
  logic        sat_prev;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      model_acc = 0;
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 32'd1);
        chk("hold_sum", sum, sum_prev);
        chk("hold_sat", sat, sat_prev);
      end
      if (out_valid && !out_ready) begin
        held_cycles++;
        chk("hold_in_ready", in_ready, 32'd0);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %h expected none", sum);
        end else begin
          exp_e = exp_q.pop_front();
          chk("sb_sum", sum, exp_e.s);
          chk("sb_sat", sat, exp_e.st);
        end
      end
      if (in_valid && in_ready) begin
        model_acc += beat_value(a_flat, b_flat);
        if (in_last) begin
          exp_q.push_back(ref_result(model_acc));
          model_acc = 0;
        end
      end
      hold_prev = out_valid && !out_ready;
      sum_prev  = sum;
      sat_prev  = sat;
    end
  end

  // ---------------- driver helpers ----------------
  int last_acc_cyc = 0;
  int waits = 0;

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic last);
    a_flat = a; b_flat = b; in_last = last; in_valid = 1'b1;
    waits = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
    end
    if (waits >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
    end
    last_acc_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Waits for out_valid; lat = negedge count since the accepting cycle.
  task automatic wait_out(output logic [15:0] s, output logic st, output int lat);
    int n;
    s = 16'h0; st = 1'b0; lat = -1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL output_timeout: got no out_valid expected result within 100 cycles");
    end else begin
      s = sum; st = sat; lat = cyc - last_acc_cyc;
    end
  endtask

  task automatic drain(input int expect_outs, input int n0, input string name);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (8) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 32'd0);
    chk({name, "_count"}, n_out - n0, expect_outs);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd_lanes(input int mode);
    logic [63:0] v;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      if (mode == 0) v[i*16 +: 16] = r[15:0];
      else           v[i*16 +: 16] = {{8{r[7]}}, r[7:0]};
    end
    return v;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] es;
    logic        es_sat;
  } vec_t;

`ifdef MULADD_PIPE_ROUND_EN
  localparam logic [15:0] EXP_SMALL = 16'h0001;
  localparam logic [15:0] EXP_NEG1  = 16'h0000;
`else
  localparam logic [15:0] EXP_SMALL = 16'h0000;
  localparam logic [15:0] EXP_NEG1  = 16'hFFFF;
`endif

  localparam int NV = 9;
  vec_t vecs[NV];

  logic [15:0] got_s;
  logic        got_st;
  int          lat;
  int          pulses;
  int          n0;
  logic        done;

  initial begin
    vecs[0] = '{"one_x_two",  {4{16'h0100}}, {4{16'h0200}}, 16'h0800, 1'b0};
    vecs[1] = '{"max_sat",    {4{16'h7FFF}}, {4{16'h7FFF}}, 16'h7FFF, 1'b1};
    vecs[2] = '{"min_sat",    {4{16'h8000}}, {4{16'h7FFF}}, 16'h8000, 1'b1};
    vecs[3] = '{"neg_one",    {4{16'hFF00}}, {4{16'h0100}}, 16'hFC00, 1'b0};
    vecs[4] = '{"round_half", 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080, EXP_SMALL, 1'b0};
    vecs[5] = '{"neg_lsb",    64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, EXP_NEG1, 1'b0};
    vecs[6] = '{"mixed",      {16'h0040, 16'hFF80, 16'h0200, 16'h0100},
                              {16'h0100, 16'h0100, 16'hFE00, 16'h0300}, 16'hFEC0, 1'b0};
    vecs[7] = '{"edge_max",   64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0100, 16'h7FFF, 1'b0};
    vecs[8] = '{"edge_min",   64'h0000_0000_0000_8000, 64'h0000_0000_0000_0100, 16'h8000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a_flat = '0; b_flat = '0; out_ready = 1'b1;
    done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_sat", sat, 32'd0);
    chk("rst_in_ready", in_ready, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 32'd1);
    @(posedge clk); #1;

    // Table: single-beat packets, latency and one-cycle pulse
    for (int k = 0; k < NV; k++) begin
      send_beat(vecs[k].a, vecs[k].b, 1'b1);
      idle();
      wait_out(got_s, got_st, lat);
      chk({vecs[k].name, "_sum"}, got_s, vecs[k].es);
      chk({vecs[k].name, "_sat"}, got_st, vecs[k].es_sat);
      chk({vecs[k].name, "_latency"}, lat, 32'd4);
      @(negedge clk);
      chk({vecs[k].name, "_pulse_end"}, out_valid, 32'd0);
      @(posedge clk); #1;
    end

    // Three back-to-back beats in one packet
    send_beat(vecs[0].a, vecs[0].b, 1'b0);
    chk("b2b_wait0", waits, 32'd0);
    send_beat(vecs[0].a, vecs[0].b, 1'b0);
    chk("b2b_wait1", waits, 32'd0);
    send_beat(vecs[0].a, vecs[0].b, 1'b1);
    chk("b2b_wait2", waits, 32'd0);
    idle();
    wait_out(got_s, got_st, lat);
    chk("b2b_sum", got_s, 32'h1800);
    chk("b2b_sat", got_st, 32'd0);
    chk("b2b_latency", lat, 32'd4);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("b2b_extra_pulses", pulses, 32'd0);
    @(posedge clk); #1;

    // Backpressure: hold out_ready low for 5 cycles once a result is held
    n0 = n_out;
    held_cycles = 0;
    fork
      begin
        out_ready = 1'b0;
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int p = 0; p < 6; p++) send_beat(rnd_lanes(1), rnd_lanes(1), 1'b1);
        idle();
      end
    join
    drain(6, n0, "bp");
    chk("bp_held_seen", held_cycles >= 4, 32'd1);

    // Reset in the middle of a packet
    send_beat(vecs[0].a, vecs[0].b, 1'b0);
    send_beat(vecs[0].a, vecs[0].b, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 32'd0);
    chk("midrst_sum", sum, 32'd0);
    @(posedge clk); #1;
    n0 = n_out;
    send_beat(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0100, 1'b1);
    idle();
    wait_out(got_s, got_st, lat);
    chk("midrst_result", got_s, 32'h0100);
    chk("midrst_result_sat", got_st, 32'd0);
    drain(1, n0, "midrst");

    // Randomised packets with random backpressure and input gaps
    n0 = n_out;
    fork
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 5);
          for (int bt = 0; bt < len; bt++) begin
            send_beat(rnd_lanes($urandom_range(0, 1)), rnd_lanes($urandom_range(0, 1)), bt == len - 1);
            if ($urandom_range(0, 3) == 0) begin
              idle();
              repeat ($urandom_range(1, 2)) @(posedge clk);
              #1;
            end
          end
        end
        idle();
        done = 1'b1;
      end
    join
    drain(40, n0, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected end of test before 400000");
    $fatal(1);
  end

endmodule
